// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: folds PS/2 make/break sequences (E0/F0 prefixes) onto one canonical WASD code per direction; define KEY_RELEASE_CLEAR_EN to also zero the code when the key is released
module ps2_key_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_byte_valid,
  input  logic       clear,
  output logic [7:0] last_key_received,
  output logic       key_held,
  output logic       key_event
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [7:0] key_nx, code;
  logic held_nx, event_nx, ext, brk;
  // canonical code of the byte in the current prefix context; 00 marks an untracked key
  always_comb begin
    ext = state == GOT_E0 || state == GOT_E0F0;
    brk = state == GOT_F0 || state == GOT_E0F0;
    code = 8'h00;
    if (ext)
      case (ps2_byte)
        8'h75:   code = 8'h1D;
        8'h6B:   code = 8'h1C;
        8'h72:   code = 8'h1B;
        8'h74:   code = 8'h23;
        default: code = 8'h00;
      endcase
    else if (ps2_byte inside {8'h1D, 8'h1C, 8'h1B, 8'h23})
      code = ps2_byte;
  end
  // prefix tracking, make/break handling and prefix timeout; clear beats a same-cycle byte
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    key_nx = last_key_received;
    held_nx = key_held;
    event_nx = 1'b0;
    if (clear) begin
      state_nx = IDLE;
      cnt_nx = '0;
      key_nx = 8'h00;
      held_nx = 1'b0;
    end else if (ps2_byte_valid) begin
      cnt_nx = '0;
      if (ps2_byte == 8'hE0)
        state_nx = GOT_E0;
      else if (ps2_byte == 8'hF0)
        state_nx = state == IDLE ? GOT_F0 : state == GOT_E0 ? GOT_E0F0 : state;
      else begin
        state_nx = IDLE;
        if (code != 8'h00 && !brk) begin
          key_nx = code;
          held_nx = 1'b1;
          event_nx = 1'b1;
        end else if (code != 8'h00 && code == last_key_received) begin
          held_nx = 1'b0;
`ifdef KEY_RELEASE_CLEAR_EN
          key_nx = 8'h00;
`endif
        end
      end
    end else if (state != IDLE) begin
      state_nx = cnt == CNT_MAX ? IDLE : state;
      cnt_nx = cnt == CNT_MAX ? '0 : cnt + 1'b1;
    end
  end
  // registered state and outputs
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      last_key_received <= 8'h00;
      key_held <= 1'b0;
      key_event <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      last_key_received <= key_nx;
      key_held <= held_nx;
      key_event <= event_nx;
    end
  end
endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder: directed and random byte streams checked against a prefix/keymap reference model
module tb_ps2_key_decoder;
  localparam int T = 20;
  logic clock = 0, resetn = 0, ps2_byte_valid = 0, clear = 0;
  logic [7:0] ps2_byte = 0;
  logic [7:0] last_key_received;
  logic key_held, key_event;
  int errors = 0, checks = 0, cycle = 0, last_edge = 0, evt_count = 0;
  logic [7:0] m_key = 0;
  logic m_held = 0, m_evt = 0, pre_ext = 0, pre_brk = 0;
  logic [7:0] wasd[4] = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
  logic [7:0] arrows[4] = '{8'h75, 8'h6B, 8'h72, 8'h74};
  logic [7:0] pool[16] = '{8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h1D, 8'h1C, 8'h1B, 8'h23,
                           8'h75, 8'h6B, 8'h72, 8'h74, 8'hAA, 8'hE1, 8'h00, 8'hFF};

  always #5 clock = ~clock;

  ps2_key_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .resetn(resetn), .ps2_byte(ps2_byte), .ps2_byte_valid(ps2_byte_valid),
    .clear(clear), .last_key_received(last_key_received), .key_held(key_held), .key_event(key_event)
  );

  task automatic check(string tag, string what, logic [7:0] got, logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s got=%h exp=%h", tag, what, got, exp);
    end
  endtask

  function automatic logic [7:0] canon(logic ext, logic [7:0] b);
    for (int i = 0; i < 4; i++)
      if ((!ext && b == wasd[i]) || (ext && b == arrows[i])) return wasd[i];
    return 8'h00;
  endfunction

  task automatic model(logic v, logic [7:0] b, logic clr);
    logic [7:0] c;
    m_evt = 0;
    if (clr) begin
      m_key = 0; m_held = 0; pre_ext = 0; pre_brk = 0;
    end else if (v) begin
      if ((pre_ext || pre_brk) && cycle - last_edge > T) begin pre_ext = 0; pre_brk = 0; end
      last_edge = cycle;
      if (b == 8'hE0) begin pre_ext = 1; pre_brk = 0; end
      else if (b == 8'hF0) pre_brk = 1;
      else begin
        c = canon(pre_ext, b);
        if (c != 0 && !pre_brk) begin m_key = c; m_held = 1; m_evt = 1; end
        else if (c != 0 && c == m_key) begin
          m_held = 0;
`ifdef KEY_RELEASE_CLEAR_EN
          m_key = 0;
`endif
        end
        pre_ext = 0; pre_brk = 0;
      end
    end
  endtask

  task automatic verify(string tag);
    check(tag, "key", last_key_received, m_key);
    check(tag, "held", {7'b0, key_held}, {7'b0, m_held});
    check(tag, "event", {7'b0, key_event}, {7'b0, m_evt});
  endtask

  task automatic cyc(logic v, logic [7:0] b, logic clr, string tag);
    ps2_byte_valid = v; ps2_byte = b; clear = clr;
    @(posedge clock);
    cycle++;
    model(v, b, clr);
    #1;
    verify(tag);
    if (key_event) evt_count++;
    ps2_byte_valid = 0; clear = 0;
  endtask

  task automatic send(logic [7:0] b, string tag);
    cyc(1, b, 0, tag);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) cyc(0, 8'h00, 0, tag);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    verify("reset");
    resetn = 1;
    send(8'h75, "keypad"); send(8'hF0, "keypad_brk"); send(8'h75, "keypad_brk"); send(8'hAA, "bat");
    check("untracked", "key", last_key_received, 8'h00);
    check("untracked", "events", evt_count[7:0], 8'd0);
    send(8'h1D, "basic");
    check("basic", "key_const", last_key_received, 8'h1D);
    idle(1, "basic_pulse_end");
    send(8'hE0, "arrow"); send(8'h6B, "arrow_make");
    check("arrow", "key_const", last_key_received, 8'h1C);
    send(8'hE0, "arrow_brk"); send(8'hF0, "arrow_brk"); send(8'h6B, "arrow_brk");
    check("arrow_brk", "held_const", {7'b0, key_held}, 8'd0);
    send(8'hE0, "to_long"); idle(T + 2, "to_long_gap"); send(8'h75, "to_long");
    send(8'hE0, "to_short"); idle(T - 2, "to_short_gap"); send(8'h75, "to_short");
    check("to_short", "key_const", last_key_received, 8'h1D);
    send(8'hE0, "to_edge"); idle(T - 1, "to_edge_gap"); send(8'h72, "to_edge");
    send(8'hE0, "to_over"); idle(T, "to_over_gap"); send(8'h74, "to_over");
    evt_count = 0;
    send(8'h23, "repl"); send(8'h23, "repeat"); send(8'h1B, "repl"); send(8'hF0, "old_brk"); send(8'h23, "old_brk");
    check("repl", "events", evt_count[7:0], 8'd3);
    check("repl", "key_const", last_key_received, 8'h1B);
    send(8'h1D, "pre_clear");
    cyc(1, 8'h23, 1, "clear_collide");
    check("clear_collide", "key_const", last_key_received, 8'h00);
    send(8'hE0, "mid_reset");
    #2 resetn = 0;
    #1;
    m_key = 0; m_held = 0; m_evt = 0; pre_ext = 0; pre_brk = 0;
    verify("mid_reset");
    @(negedge clock) resetn = 1;
    send(8'h75, "after_reset");
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 5) cyc(1'($urandom_range(0, 1)), pool[$urandom_range(0, 15)], 1, "rnd_clear");
      else if (r < 9) idle($urandom_range(T - 1, T + 2), "rnd_gap_long");
      else if (r < 30) idle($urandom_range(1, 3), "rnd_gap");
      else send(pool[$urandom_range(0, 15)], "rnd_byte");
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
